mult_div_ctrl: RTL and testbench
================================

Name: mult_div_ctrl

Overview:
- Sequencing controller plus iterative engine for the CPU's shared multiply/divide resource.
- Accepts a start pulse from the main control unit with operands taken from the A and B register outputs.
- Runs a signed radix-2 multiply or a signed restoring divide over WIDTH cycles.
- Drives the HI/LO result buses and their write strobes; raises a divide-by-zero flag toward the exception control logic.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request from the control unit; sampled only in IDLE
- op  input  1  0 = mult (signed), 1 = div (signed); sampled with start
- a_in  input  WIDTH  operand A: multiplicand or dividend
- b_in  input  WIDTH  operand B: multiplier or divisor
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- hi_out  output  WIDTH  HI result, registered, holds until next write
- lo_out  output  WIDTH  LO result, registered, holds until next write
- hi_write  output  1  pulse, coincident with done when HI is updated
- lo_write  output  1  pulse, coincident with done when LO is updated
- div_zero  output  1  pulse, coincident with done on divide by zero

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values: state IDLE, iteration counter 0. Outputs busy, done, hi_write, lo_write and div_zero are 0. hi_out and lo_out are 0.
- States: IDLE, MULT, DIV, FINISH.
- IDLE with start=1:
  - Latch a_in, b_in and op; load counter = WIDTH.
  - Go to MULT (op=0) or DIV (op=1).
  - Exception: op=1 with b_in=0 goes directly to FINISH with the div_zero flag set.
- MULT:
  - Booth radix-2 on a 2*WIDTH+1 product register.
  - One step per cycle; counter decrements each step.
  - Go to FINISH when the counter reaches 0 (WIDTH cycles).
- DIV:
  - Operate on the magnitudes of dividend and divisor; one restoring step per cycle; WIDTH cycles.
  - Apply signs in FINISH:
    - quotient negated when the operand signs differ;
    - remainder takes the sign of the dividend.
- FINISH (one cycle):
  - Assert done.
  - Normal completion: also assert hi_write and lo_write, and update hi_out/lo_out on the same edge.
  - Mult: hi_out = product[2W-1:W], lo_out = product[W-1:0].
  - Div: lo_out = quotient, hi_out = remainder.
  - Return to IDLE.
- Latency:
  - start accepted at edge 0; done high during cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - Divide by zero: done high during cycle 1.
- busy is high in MULT, DIV and FINISH; low in IDLE.
- start while busy is ignored: no queuing, no effect on the running operation.
- start in the same cycle FINISH returns to IDLE is ignored. A new start is accepted only when IDLE was the registered state in that cycle.
- Overflow case: div -2^(W-1) / -1 gives lo_out = 0x80000000, hi_out = 0. Wraps, no flag.
- Reset mid-operation: abort immediately to IDLE; no done or write pulse; hi_out/lo_out cleared to 0.
- done, hi_write, lo_write and div_zero are never high for more than one consecutive cycle.

Optional Feature:
- Macro: MULT_DIV_DIVZERO_TRAP_EN.
- Defined:
  - div with b_in=0 produces a 1-cycle-latency FINISH with done=1, div_zero=1, hi_write=0, lo_write=0.
  - hi_out/lo_out are unchanged.
- Undefined:
  - div_zero is tied to 0.
  - Divide by zero runs the full WIDTH iterations.
  - FINISH writes lo_out = all-ones and hi_out = dividend, with hi_write=lo_write=1.

Test Plan:
- mult a=7, b=-3 (0xFFFFFFFD) -> done in cycle 33; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; hi_write=lo_write=1 for exactly one cycle.
- mult a=0x80000000, b=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
- div a=-7, b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). Then div a=0x80000000, b=-1 -> lo_out=0x80000000, hi_out=0.
- div a=5, b=0:
  - with MULT_DIV_DIVZERO_TRAP_EN: done=div_zero=1 in cycle 1, no writes, hi/lo keep prior values;
  - without it: done in cycle 33, lo_out=0xFFFFFFFF, hi_out=5.
- mult 3*4 started, then start with op=1, a=9, b=3 pulsed at cycle 10 -> ignored; result hi_out=0, lo_out=12 at cycle 33; busy low at cycle 34.
- mult started, reset asserted at cycle 15 -> next edge: busy=0, hi_out=lo_out=0, no done pulse. A subsequent mult 2*2 yields lo_out=4.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// Shared multiply/divide engine: signed radix-2 Booth multiply and signed restoring divide, WIDTH steps each.
// Optional macro MULT_DIV_DIVZERO_TRAP_EN: divide by zero finishes in one cycle with div_zero and no HI/LO write.
module mult_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write,
  output logic             div_zero
);

  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MULT   = 2'd1,
    S_DIV    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_mcand, w_mcand;
  logic [PW-1:0]    r_prod, w_prod;
  logic [WIDTH-1:0] r_rem, w_rem;
  logic [WIDTH-1:0] r_quo, w_quo;
  logic [WIDTH-1:0] r_dsor, w_dsor;
  logic [WIDTH-1:0] r_dvnd, w_dvnd;
  logic             r_neg_q, w_neg_q;
  logic             r_neg_r, w_neg_r;
  logic             r_dz, w_dz;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_hi_wr, w_hi_wr;
  logic             r_lo_wr, w_lo_wr;
  logic             r_div_zero, w_div_zero;
  logic [WIDTH-1:0] r_hi, w_hi;
  logic [WIDTH-1:0] r_lo, w_lo;

  logic [WIDTH:0]   w_acc;
  logic [WIDTH:0]   w_mext;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_prod_step;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic [WIDTH-1:0] w_q_signed;
  logic [WIDTH-1:0] w_r_signed;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_b_zero;

  // One Booth step and one restoring-divide step; the accumulator is one bit wider so -2^(W-1) operands cannot overflow.
  always_comb begin
    w_acc  = {r_prod[PW-1], r_prod[PW-1:WIDTH+1]};
    w_mext = {r_mcand[WIDTH-1], r_mcand};
    case (r_prod[1:0])
      2'b01:   w_sum = w_acc + w_mext;
      2'b10:   w_sum = w_acc - w_mext;
      default: w_sum = w_acc;
    endcase
    w_prod_step = {w_sum, r_prod[WIDTH:1]};

    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_dsor});
    w_trial    = w_shift[WIDTH-1:0] - r_dsor;
    w_rem_step = w_ge ? w_trial : w_shift[WIDTH-1:0];
    w_quo_step = {r_quo[WIDTH-2:0], w_ge};
    w_q_signed = r_neg_q ? (WIDTH'(0) - w_quo_step) : w_quo_step;
    w_r_signed = r_neg_r ? (WIDTH'(0) - w_rem_step) : w_rem_step;

    w_a_abs  = a_in[WIDTH-1] ? (WIDTH'(0) - a_in) : a_in;
    w_b_abs  = b_in[WIDTH-1] ? (WIDTH'(0) - b_in) : b_in;
    w_b_zero = (b_in == '0);
  end

  // Next state, datapath loads and registered output values.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_mcand    = r_mcand;
    w_prod     = r_prod;
    w_rem      = r_rem;
    w_quo      = r_quo;
    w_dsor     = r_dsor;
    w_dvnd     = r_dvnd;
    w_neg_q    = r_neg_q;
    w_neg_r    = r_neg_r;
    w_dz       = r_dz;
    w_hi       = r_hi;
    w_lo       = r_lo;
    w_hi_wr    = 1'b0;
    w_lo_wr    = 1'b0;
    w_div_zero = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt   = CW'(WIDTH);
          w_mcand = a_in;
          w_prod  = {WIDTH'(0), b_in, 1'b0};
          w_rem   = '0;
          w_quo   = w_a_abs;
          w_dsor  = w_b_abs;
          w_dvnd  = a_in;
          w_neg_q = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          w_neg_r = a_in[WIDTH-1];
          w_dz    = op & w_b_zero;
          if (!op) begin
            w_state = S_MULT;
          end else begin
            w_state = S_DIV;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
            if (w_b_zero) begin
              w_state    = S_FINISH;
              w_cnt      = '0;
              w_div_zero = 1'b1;
            end
`endif
          end
        end
      end
      S_MULT: begin
        w_prod = w_prod_step;
        w_cnt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state = S_FINISH;
          w_hi    = w_prod_step[PW-1:WIDTH+1];
          w_lo    = w_prod_step[WIDTH:1];
          w_hi_wr = 1'b1;
          w_lo_wr = 1'b1;
        end
      end
      S_DIV: begin
        w_rem = w_rem_step;
        w_quo = w_quo_step;
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state = S_FINISH;
          w_hi_wr = 1'b1;
          w_lo_wr = 1'b1;
          // A zero divisor still iterates, but reports all-ones quotient and the raw dividend.
          if (r_dz) begin
            w_hi = r_dvnd;
            w_lo = '1;
          end else begin
            w_hi = w_r_signed;
            w_lo = w_q_signed;
          end
        end
      end
      S_FINISH: w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase

    w_done = (w_state == S_FINISH);
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dsor     <= '0;
      r_dvnd     <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi_wr    <= 1'b0;
      r_lo_wr    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_cnt      <= w_cnt;
      r_mcand    <= w_mcand;
      r_prod     <= w_prod;
      r_rem      <= w_rem;
      r_quo      <= w_quo;
      r_dsor     <= w_dsor;
      r_dvnd     <= w_dvnd;
      r_neg_q    <= w_neg_q;
      r_neg_r    <= w_neg_r;
      r_dz       <= w_dz;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_hi_wr    <= w_hi_wr;
      r_lo_wr    <= w_lo_wr;
      r_div_zero <= w_div_zero;
      r_hi       <= w_hi;
      r_lo       <= w_lo;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;
  assign hi_write = r_hi_wr;
  assign lo_write = r_lo_wr;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed cases with literal results plus random traffic checked each cycle
// against an arithmetic model (latency countdown + 64-bit signed multiply/divide).
module tb_mult_div_ctrl;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, hi_write, lo_write, div_zero;
  logic [W-1:0] hi_out, lo_out;

  mult_div_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .hi_write(hi_write),
    .lo_write(lo_write), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         wr;
    logic         dz;
  } res_t;

  // Architectural result of one operation.
  function automatic res_t model_res(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   r;
    longint p, q, m;
    r.wr = 1'b1;
    r.dz = 1'b0;
    r.hi = '0;
    r.lo = '0;
    if (!o) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == '0) begin
`ifdef MULT_DIV_DIVZERO_TRAP_EN
      r.wr = 1'b0;
      r.dz = 1'b1;
`else
      r.lo = '1;
      r.hi = a;
`endif
    end else begin
      q    = longint'($signed(a)) / longint'($signed(b));
      m    = longint'($signed(a)) % longint'($signed(b));
      r.lo = q[31:0];
      r.hi = m[31:0];
    end
    return r;
  endfunction

  // Cycles from acceptance to the done cycle, inclusive.
  function automatic int model_lat(input logic o, input logic [W-1:0] b);
`ifdef MULT_DIV_DIVZERO_TRAP_EN
    if (o && b == '0) return 1;
`endif
    return int'(W) + 1;
  endfunction

  int           m_left = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  res_t         m_pend = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend <= model_res(op, a_in, b_in);
        m_left <= model_lat(op, b_in);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2 && m_pend.wr) begin
        m_hi <= m_pend.hi;
        m_lo <= m_pend.lo;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy",     64'(busy),     64'(m_left > 0));
      chk("done",     64'(done),     64'(m_left == 1));
      chk("hi_write", 64'(hi_write), 64'(m_left == 1 && m_pend.wr));
      chk("lo_write", 64'(lo_write), 64'(m_left == 1 && m_pend.wr));
      chk("div_zero", 64'(div_zero), 64'(m_left == 1 && m_pend.dz));
      chk("hi_out",   64'(hi_out),   64'(m_hi));
      chk("lo_out",   64'(lo_out),   64'(m_lo));
    end
  end

  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intf, input int exp_lat, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic ewr, input logic edz,
                        input string nm);
    int lat;
    lat = 0;
    @(negedge clock);
    start = 1'b1; op = o; a_in = a; b_in = b;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      start = (i == intf);
      if (i == intf) begin
        op = 1'b1; a_in = 32'd9; b_in = 32'd3;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " hi"}, 64'(hi_out), 64'(ehi));
    chk({nm, " lo"}, 64'(lo_out), 64'(elo));
    chk({nm, " strobes"}, 64'({hi_write, lo_write, div_zero}), 64'({ewr, ewr, edz}));
    @(negedge clock);
    chk({nm, " after done"}, 64'({done, hi_write, lo_write, div_zero, busy}), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int ndone;
    @(posedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("reset state", 64'({busy, done, hi_write, lo_write, div_zero, hi_out, lo_out}), 64'(0));
    reset = 1'b0;

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0, "mul_7_m3");
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 33, 32'h4000_0000, 32'h0, 1'b1, 1'b0, "mul_min_min");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0, "div_m7_2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 32'h0, 32'h8000_0000, 1'b1, 1'b0, "div_ovf");
`ifdef MULT_DIV_DIVZERO_TRAP_EN
    run_op(1'b1, 32'd5, 32'd0, 0, 1, 32'h0, 32'h8000_0000, 1'b0, 1'b1, "div_5_0");
`else
    run_op(1'b1, 32'd5, 32'd0, 0, 33, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_5_0");
`endif
    run_op(1'b0, 32'd3, 32'd4, 10, 33, 32'h0, 32'd12, 1'b1, 1'b0, "mul_3_4_busy_start");

    // Reset in the middle of a multiply.
    @(negedge clock);
    start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd5;
    repeat (15) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_abort state", 64'({busy, done, hi_write, lo_write, hi_out, lo_out}), 64'(0));
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("rst_abort no done", 64'(ndone), 64'(0));
    run_op(1'b0, 32'd2, 32'd2, 0, 33, 32'h0, 32'd4, 1'b1, 1'b0, "mul_2_2");

    for (int c = 0; c < 9000; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 7) == 0);
      op    = 1'($urandom_range(0, 1));
      a_in  = pick();
      b_in  = pick();
    end
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
